// File: rtl/or_arbiter_pkg.sv
// Shared types and default sizing for the OR arbiter slice.
package or_arbiter_pkg;

    localparam int N_DEF = 4;
    localparam int W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/or_unit.sv
// Shared bitwise-OR datapath; result width equals operand width.
module or_unit
    import or_arbiter_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] c
);

    assign c = a | b;

endmodule

// File: rtl/or_arbiter.sv
// Round-robin arbiter granting N requesters access to one shared OR unit.
// Define OR_ARBITER_LOCK_EN to add the lock input that pins rr_ptr on the winner.
module or_arbiter
    import or_arbiter_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       op_a,
    input  logic [N*W-1:0]       op_b,
    output logic [N-1:0]         gnt,
    output logic [W-1:0]         res,
    output logic                 res_valid,
    output logic [$clog2(N)-1:0] res_id,
    output logic                 busy
`ifdef OR_ARBITER_LOCK_EN
    ,
    input  logic [N-1:0]         lock
`endif
);

    localparam int IW = $clog2(N);

    state_t        state, state_nxt;
    logic [IW-1:0] rr_ptr, sel;
    logic [IW-1:0] pick, hi_pick, lo_pick;
    logic          hi_found, lo_found;
    logic [W-1:0]  a_sel, b_sel, or_c;
    logic          lock_hold;

    // Lowest requester at/above rr_ptr wins; otherwise wrap to the lowest below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_pick  = '0;
        lo_pick  = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (req[j]) begin
                if (j >= 32'(rr_ptr)) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_pick  = IW'(j);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_pick  = IW'(j);
                end
            end
        end
        pick = hi_found ? hi_pick : lo_pick;
    end

    always_comb begin
        a_sel     = '0;
        b_sel     = '0;
        lock_hold = 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
            if (sel == IW'(j)) begin
                a_sel = op_a[j*W +: W];
                b_sel = op_b[j*W +: W];
`ifdef OR_ARBITER_LOCK_EN
                lock_hold = lock[j];
`endif
            end
        end
    end

    or_unit #(.W(W)) u_or_unit (
        .a (a_sel),
        .b (b_sel),
        .c (or_c)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = GRANT;
            GRANT:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt = '0;
        for (int unsigned j = 0; j < N; j++) begin
            gnt[j] = (state == GRANT) && (sel == IW'(j));
        end
        res_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    // Result is registered at the end of GRANT, so it holds through RESP and beyond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel    <= '0;
            rr_ptr <= '0;
            res    <= '0;
            res_id <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                sel <= pick;
            end
            if (state == GRANT) begin
                res    <= or_c;
                res_id <= sel;
                if (lock_hold) begin
                    rr_ptr <= sel;
                end else if (sel == IW'(N-1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= sel + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_or_arbiter.sv
// Directed self-checking bench for or_arbiter (N=4, W=8).
module tb_or_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  gnt;
    logic [7:0]  res;
    logic        res_valid;
    logic [1:0]  res_id;
    logic        busy;
`ifdef OR_ARBITER_LOCK_EN
    logic [3:0]  lock;
`endif

    int checks = 0;
    int errors = 0;

    or_arbiter #(.N(4), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .gnt       (gnt),
        .res       (res),
        .res_valid (res_valid),
        .res_id    (res_id),
        .busy      (busy)
`ifdef OR_ARBITER_LOCK_EN
        ,
        .lock      (lock)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Issues one request pattern, waits (bounded) for its grant and samples the RESP cycle.
    task automatic run_grant(input logic [3:0] v, output logic [3:0] g,
                             output logic [7:0] r, output logic [1:0] id, output logic rv);
        g  = '0;
        r  = '0;
        id = '0;
        rv = 1'b0;
        req = v;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (gnt !== 4'b0) break;
        end
        g   = gnt;
        req = '0;
        @(posedge clk); #1;
        r  = res;
        id = res_id;
        rv = res_valid;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (gnt !== 4'b0)    begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if (res !== 8'h00)   begin errors++; $display("FAIL reset_res: got %h expected 00", res); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
        checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", res_id); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_idle: busy got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        op_a = 32'h0000_000F;
        op_b = 32'h0000_00F0;
        req  = 4'b0001;
        @(posedge clk); #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL basic_gnt: got %b expected 0001", gnt); end
        checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        req = 4'b0000;
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", res_valid); end
        checks++; if (res !== 8'hFF)   begin errors++; $display("FAIL basic_res: got %h expected ff", res); end
        checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL basic_id: got %0d expected 0", res_id); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL basic_gnt_off: got %b expected 0000", gnt); end
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_off: got %b expected 0", res_valid); end
        checks++; if (res !== 8'hFF)   begin errors++; $display("FAIL basic_res_hold: got %h expected ff", res); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL basic_idle: got %b expected 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_res [4];
        logic [3:0] exp_g;
        exp_res = '{8'h11, 8'h22, 8'h44, 8'h88};
        do_reset();
        op_a = {8'h08, 8'h04, 8'h02, 8'h01};
        op_b = {8'h80, 8'h40, 8'h20, 8'h10};
        req  = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            exp_g = (c % 3 == 0) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt c=%0d: got %b expected %b", c, gnt, exp_g); end
            if (c % 3 == 1) begin
                checks++;
                if (res_valid !== 1'b1 || res !== exp_res[(c / 3) % 4] || res_id !== 2'((c / 3) % 4)) begin
                    errors++;
                    $display("FAIL rr_res c=%0d: got v=%b res=%h id=%0d expected v=1 res=%h id=%0d",
                             c, res_valid, res, res_id, exp_res[(c / 3) % 4], (c / 3) % 4);
                end
            end
            if (c == 14) req = 4'b0000;
        end
        @(posedge clk); #1;
        checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rr_stop: got gnt=%b busy=%b expected 0000/0", gnt, busy); end
    endtask

    task automatic test_wrap();
        logic [3:0] g;
        logic [7:0] r;
        logic [1:0] id;
        logic       rv;
        run_grant(4'b1000, g, r, id, rv);
        checks++; if (g !== 4'b1000) begin errors++; $display("FAIL wrap_g3: got %b expected 1000", g); end
        checks++; if (rv !== 1'b1 || r !== 8'h88 || id !== 2'd3) begin errors++; $display("FAIL wrap_res3: got v=%b res=%h id=%0d expected v=1 res=88 id=3", rv, r, id); end
        run_grant(4'b1001, g, r, id, rv);
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL wrap_g0: got %b expected 0001", g); end
        run_grant(4'b1000, g, r, id, rv);
        checks++; if (g !== 4'b1000) begin errors++; $display("FAIL wrap_g3b: got %b expected 1000", g); end
    endtask

    task automatic test_operand_capture();
        logic seen;
        seen = 1'b0;
        op_a = 32'h0000_A500;
        op_b = 32'h0000_5A00;
        req  = 4'b0010;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (gnt !== 4'b0) begin seen = 1'b1; break; end
        end
        checks++; if (!seen || gnt !== 4'b0010) begin errors++; $display("FAIL cap_gnt: got %b expected 0010", gnt); end
        req = 4'b0000;
        @(posedge clk); #1;
        op_a = 32'hC3C3_A53C;
        op_b = 32'h7E7E_5A11;
        #2;
        checks++; if (res_valid !== 1'b1 || res !== 8'hFF || res_id !== 2'd1) begin errors++; $display("FAIL cap_res: got v=%b res=%h id=%0d expected v=1 res=ff id=1", res_valid, res, res_id); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic       seen;
        logic       stray;
        logic [3:0] g;
        logic [7:0] r;
        logic [1:0] id;
        logic       rv;
        seen  = 1'b0;
        stray = 1'b0;
        req   = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (gnt !== 4'b0) begin seen = 1'b1; break; end
        end
        checks++; if (!seen || gnt !== 4'b0100) begin errors++; $display("FAIL mid_gnt: got %b expected 0100", gnt); end
        req = 4'b0000;
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL mid_resp: got %b expected 1", res_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0) begin errors++; $display("FAIL mid_rst: got v=%b busy=%b gnt=%b expected 0/0/0000", res_valid, busy, gnt); end
        checks++; if (res !== 8'h00 || res_id !== 2'd0) begin errors++; $display("FAIL mid_rst_res: got res=%h id=%0d expected 00/0", res, res_id); end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (res_valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL mid_after: got stray activity=%b expected 0", stray); end
        run_grant(4'b1010, g, r, id, rv);
        checks++; if (g !== 4'b0010) begin errors++; $display("FAIL mid_next: got %b expected 0010", g); end
    endtask

`ifdef OR_ARBITER_LOCK_EN
    task automatic test_lock();
        logic [3:0] g;
        logic [7:0] r;
        logic [1:0] id;
        logic       rv;
        do_reset();
        lock = 4'b0000;
        run_grant(4'b0010, g, r, id, rv);
        checks++; if (g !== 4'b0010) begin errors++; $display("FAIL lock_setup: got %b expected 0010", g); end
        lock = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            run_grant(4'b0110, g, r, id, rv);
            checks++; if (g !== 4'b0100) begin errors++; $display("FAIL lock_hold k=%0d: got %b expected 0100", k, g); end
        end
        lock = 4'b0000;
        run_grant(4'b0110, g, r, id, rv);
        checks++; if (g !== 4'b0100) begin errors++; $display("FAIL lock_last: got %b expected 0100", g); end
        run_grant(4'b0110, g, r, id, rv);
        checks++; if (g !== 4'b0010) begin errors++; $display("FAIL lock_release: got %b expected 0010", g); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req   = '0;
        op_a  = '0;
        op_b  = '0;
`ifdef OR_ARBITER_LOCK_EN
        lock  = '0;
`endif
        test_reset();
        test_basic();
        test_round_robin();
        test_wrap();
        test_operand_capture();
        test_reset_mid();
`ifdef OR_ARBITER_LOCK_EN
        test_lock();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/or_arbiter.md
OR_ARBITER -- requirements
Module: or_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing the OR datapath, 2..8.
REQ-002 Parameter W, default 8: operand and result width in bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  N  level request, one bit per requester.
REQ-006 op_a  input  N*W  requester i's operand a in bits [i*W +: W]; held stable while req[i]=1.
REQ-007 op_b  input  N*W  requester i's operand b in bits [i*W +: W]; held stable while req[i]=1.
REQ-008 gnt  output  N  one-hot grant, high for exactly one cycle per transaction.
REQ-009 res  output  W  result a|b of the granted operands.
REQ-010 res_valid  output  1  one-cycle pulse qualifying res and res_id.
REQ-011 res_id  output  $clog2(N)  index of the requester that owns res.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, GRANT and RESP, with one cycle per state for GRANT and RESP.
REQ-014 In IDLE with req!=0, the FSM SHALL select the first set req bit at or above rr_ptr, wrapping N-1 to 0, and enter GRANT; with req==0 it SHALL stay in IDLE.
REQ-015 In GRANT, gnt[sel] SHALL be 1, and op_a/op_b of sel SHALL be captured at the end of the cycle.
REQ-016 When leaving GRANT, rr_ptr SHALL become (sel+1) mod N.
REQ-017 In RESP, res_valid SHALL be 1, res SHALL equal captured a | b, and res_id SHALL equal sel; the next state SHALL be IDLE.
REQ-018 Latency: req sampled at edge k -> gnt in cycle k+1 -> res_valid in cycle k+2; the earliest next gnt is in cycle k+4.
REQ-019 req sampled during GRANT or RESP SHALL be ignored; the requester deasserts req in the cycle after its gnt.
REQ-020 A req bit that drops before being granted SHALL produce no grant and no error.
REQ-021 res and res_id SHALL hold their last values when res_valid=0; gnt SHALL be 0 outside GRANT.
REQ-022 The OR datapath SHALL have no width growth: res[j] = a[j] | b[j] for all j < W.

Reset
REQ-023 While rst_n=0, regardless of state: state=IDLE, gnt=0, res=0, res_valid=0, res_id=0, busy=0, rr_ptr=0.
REQ-024 Reset asserted mid-transaction SHALL discard that transaction, with no res_valid after release.
REQ-025 The first grant after reset release SHALL favour requester 0.

Configuration
REQ-026 Macro OR_ARBITER_LOCK_EN SHALL add an input port lock [N-1:0].
REQ-027 With OR_ARBITER_LOCK_EN defined, lock[sel]=1 during GRANT SHALL leave rr_ptr at sel, so the same requester wins the next arbitration if it is still requesting.
REQ-028 Without OR_ARBITER_LOCK_EN, the lock port SHALL be absent and rr_ptr SHALL always advance per REQ-016.

Structure
REQ-029 Package or_arbiter_pkg SHALL hold the state enum (IDLE, GRANT, RESP) and the default constants N_DEF=4 and W_DEF=8.
REQ-030 Sub-module or_unit (W-bit inputs a and b, output c = a|b) SHALL form the shared datapath, instantiated once.
REQ-031 The arbitration select logic SHALL stay inline in or_arbiter.

Verification
REQ-032 Reset release, then req=0001, op_a[0]=8'h0F, op_b[0]=8'hF0 -> gnt=0001 at k+1; res_valid=1, res=8'hFF, res_id=0 at k+2.
REQ-033 req=1111 held continuously -> grant order 0,1,2,3,0 with one grant every 3 cycles.
REQ-034 After a grant to 3, req=1001 -> next grant 0 (wrap-around); then req=1000 -> grant 3.
REQ-035 rst_n pulsed low during RESP -> res_valid=0 immediately, busy=0, next grant goes to lowest requesting index.
REQ-036 With OR_ARBITER_LOCK_EN defined and lock=0100, req=0110 -> grants 2,2,2 until lock=0000, then grant 1.
REQ-037 op_a=8'hA5, op_b=8'h5A on requester 1, while other requesters' operands change in the RESP cycle -> res=8'hFF, res_id=1.
